uartrx: RTL and testbench
=========================

# uartrx

Asynchronous serial receiver: deserialises 8N1/8N2 frames from an external line into bytes, with start-bit validation, framing-error and overrun reporting. It is the receive half of the console UART and feeds the CPU's keyboard/input device register. Its bit timing matches the team's UART transmitter exactly, so a loopback of the transmitter into this block is lossless.

## Interface
- `Baud`, 10_000_000, line bit rate.
- `ClockRate`, 50_000_000, `clk` frequency in Hz.
- Derived `RxDivider = ClockRate / Baud`; bit period = `RxDivider+1` clocks; `RxDivider >= 3` required (elaboration error otherwise).
- `clk`  input  1  system clock; all logic rising-edge.
- `nrst`  input  1  reset, asynchronous assert, active-low.
- `rx`  input  1  serial line, idle high, asynchronous to `clk`.
- `rx_data`  output  8  last received byte, LSB first on line.
- `rx_valid`  output  1  `rx_data` holds an unconsumed byte.
- `rx_ack`  input  1  consumer takes the byte; clears `rx_valid`.
- `frame_err`  output  1  one-cycle pulse: stop bit sampled low.
- `overrun`  output  1  sticky: a byte arrived while `rx_valid` was 1.

## Operation
- `rx` passes through a 2-flop synchroniser (reset value 1) → `rx_s`. Edge detect compares `rx_s` with its previous value.
- States: IDLE, START, DATA, STOP, WAIT_IDLE.
- IDLE: on `rx_s` falling edge, load bit counter with `RxDivider/2` (integer division) → START.
- Bit counter decrements each cycle; a sample is taken when it reads 0, then it reloads with `RxDivider`.
- START: sample low → DATA, bit index 0; sample high → IDLE (glitch, no output).
- DATA: shift sample into bit `[index]` (LSB first); after index 7 → STOP.
- STOP: sample high → byte committed, IDLE. Sample low → `frame_err` pulse, byte discarded, WAIT_IDLE.
- WAIT_IDLE: stay until `rx_s` == 1 (break/noise), then IDLE. No falling-edge detection here.
- Commit: `rx_data` ← shift reg, `rx_valid` ← 1. If `rx_valid` was 1 and `rx_ack` not asserted in the same cycle, `overrun` ← 1 (new byte overwrites old).
- `rx_ack` while `rx_valid`=1 clears `rx_valid` and `overrun`; `rx_ack` while `rx_valid`=0 is ignored.
- Commit and `rx_ack` in same cycle: `rx_valid` stays 1, `rx_data` = new byte, `overrun` cleared.
- Second stop bit not checked; IDLE after the first stop sample accepts an immediate next start edge (back-to-back frames).

## Timing
- Reset: state IDLE, `rx_data`=0x00, `rx_valid`=0, `frame_err`=0, `overrun`=0, synchroniser=1, counters=0. Reset mid-frame abandons the frame with no output.
- t0 = first cycle `rx_s` is low = pin fall + 2 clocks.
- Sample k (0=start, 1..8=data, 9=stop) at t0 + `RxDivider/2` + 1 + k·(`RxDivider`+1). Default: t0+3, then every 6 clocks; stop at t0+57.
- `rx_valid` rises / `frame_err` pulses the cycle after the stop sample (default t0+58).
- `rx_valid` falls the cycle after `rx_ack`.
- All outputs registered; no combinational input→output paths.

## Structure
- Package `uart_pkg`: state enum `uart_rx_state_t`, `uart_divider(ClockRate, Baud)` function, frame constants (`UART_DATA_BITS`=8, `UART_IDLE`=1'b1); shared with the transmitter.
- Sub-module `sync_2ff` (width param, reset value param) for the `rx` synchroniser; everything else in `uartrx`.

## Test plan
- Frame 0xA5 at default params, idle-high line → `rx_data`=0xA5, `rx_valid`=1 at t0+58, `frame_err`=0; `rx_ack` → `rx_valid`=0 next cycle.
- Back-to-back 0x00 then 0xFF, one stop bit gap, `rx_ack` after each → both bytes received in order, `overrun`=0.
- Two frames 0x12, 0x34 with no `rx_ack` → `rx_data`=0x34, `rx_valid`=1, `overrun`=1; `rx_ack` clears both.
- Frame 0x55 with stop bit forced low, line held low 20 bit-times → one `frame_err` pulse, `rx_valid` stays 0, no frame accepted until line high, then 0x3C received correctly.
- 2-clock low glitch on idle line → no `rx_valid`, state back to IDLE; `nrst` pulsed at t0+30 of a frame → all outputs at reset values, next clean frame 0x81 received.
- `rx_ack` in the exact commit cycle of a second byte → `rx_valid`=1, new byte in `rx_data`, `overrun`=0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame constants, receiver state encoding and
// the baud divider helper used by both the transmitter and the receiver.
package uart_pkg;

   localparam int   UART_DATA_BITS = 8;
   localparam logic UART_IDLE      = 1'b1;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP,
      RX_WAIT_IDLE
   } uart_rx_state_t;

   // Clocks per bit minus one; the bit period is uart_divider()+1 clocks.
   function automatic int uart_divider(input int clock_rate, input int baud);
      return clock_rate / baud;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for signals crossing into the clk domain.
module sync_2ff #(
   parameter int               Width      = 1,
   parameter logic [Width-1:0] ResetValue = '0
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic [Width-1:0] d_i,
   output logic [Width-1:0] q_o
);

   logic [Width-1:0] meta_q;
   logic [Width-1:0] sync_q;

   // NOTE: sequential state uses non-blocking assignments only, so every
   // flop samples the pre-edge value of its neighbour.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         meta_q <= ResetValue;
         sync_q <= ResetValue;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/uartrx.sv
// UART receiver: samples 8N1/8N2 frames mid-bit and hands bytes to a
// valid/ack consumer, flagging framing errors and overruns.
module uartrx
   import uart_pkg::*;
#(
   parameter int Baud      = 10_000_000,
   parameter int ClockRate = 50_000_000
) (
   input  logic       clk,
   input  logic       nrst,
   input  logic       rx,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ack,
   output logic       frame_err,
   output logic       overrun
);

   localparam int              RxDivider = uart_divider(ClockRate, Baud);
   localparam int              CntW      = $clog2(RxDivider + 1);
   localparam logic [CntW-1:0] HalfLoad  = CntW'(RxDivider / 2);
   localparam logic [CntW-1:0] FullLoad  = CntW'(RxDivider);
   localparam logic [2:0]      LastIdx   = 3'(UART_DATA_BITS - 1);

   generate
      if (RxDivider < 3) begin : g_divider_check
         $error("uartrx: ClockRate/Baud must be at least 3");
      end
   endgenerate

   uart_rx_state_t  state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [2:0]      idx_q, idx_d;
   logic [7:0]      shift_q, shift_d;
   logic [7:0]      data_q, data_d;
   logic            valid_q, valid_d;
   logic            ferr_q, ferr_d;
   logic            ovr_q, ovr_d;
   logic            rx_prev_q;
   logic            rx_s;
   logic            sample;

   sync_2ff #(
      .Width      (1),
      .ResetValue (UART_IDLE)
   ) u_rx_sync (
      .clk  (clk),
      .nrst (nrst),
      .d_i  (rx),
      .q_o  (rx_s)
   );

   assign sample = (cnt_q == '0);

   // NOTE: every signal driven here gets a default first, so no path through
   // the case statement can leave a latch behind.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      data_d  = data_q;
      valid_d = valid_q;
      ferr_d  = 1'b0;
      ovr_d   = ovr_q;

      if (rx_ack && valid_q) begin
         valid_d = 1'b0;
         ovr_d   = 1'b0;
      end

      if (state_q inside {RX_START, RX_DATA, RX_STOP}) begin
         cnt_d = sample ? FullLoad : cnt_q - 1'b1;
      end

      unique case (state_q)
         RX_IDLE: begin
            if (rx_prev_q && !rx_s) begin
               cnt_d   = HalfLoad;
               state_d = RX_START;
            end
         end
         RX_START: begin
            if (sample) begin
               idx_d   = '0;
               state_d = rx_s ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (sample) begin
               shift_d[idx_q] = rx_s;
               idx_d          = idx_q + 1'b1;
               if (idx_q == LastIdx) state_d = RX_STOP;
            end
         end
         RX_STOP: begin
            if (sample) begin
               if (rx_s) begin
                  // Ack in the commit cycle has already cleared the old byte.
                  data_d  = shift_q;
                  valid_d = 1'b1;
                  if (valid_q && !rx_ack) ovr_d = 1'b1;
                  state_d = RX_IDLE;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = RX_WAIT_IDLE;
               end
            end
         end
         RX_WAIT_IDLE: begin
            if (rx_s) state_d = RX_IDLE;
         end
         default: state_d = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q   <= RX_IDLE;
         cnt_q     <= '0;
         idx_q     <= '0;
         shift_q   <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         ferr_q    <= 1'b0;
         ovr_q     <= 1'b0;
         rx_prev_q <= UART_IDLE;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         shift_q   <= shift_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         ferr_q    <= ferr_d;
         ovr_q     <= ovr_d;
         rx_prev_q <= rx_s;
      end
   end

   assign rx_data   = data_q;
   assign rx_valid  = valid_q;
   assign frame_err = ferr_q;
   assign overrun   = ovr_q;

endmodule

// File: tb/tb_uartrx.sv
// Self-checking bench for uartrx: directed frames plus random traffic,
// compared against a byte-level model of the valid/ack/overrun rules.
module tb_uartrx;

   localparam int BitClks = 6;

   logic       clk;
   logic       nrst;
   logic       rx;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ack;
   logic       frame_err;
   logic       overrun;

   int checks   = 0;
   int failures = 0;
   int fe_count = 0;

   logic [7:0] exp_data;
   logic       exp_valid;
   logic       exp_ovr;

   uartrx #(
      .Baud      (10_000_000),
      .ClockRate (50_000_000)
   ) dut (
      .clk       (clk),
      .nrst      (nrst),
      .rx        (rx),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ack    (rx_ack),
      .frame_err (frame_err),
      .overrun   (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (frame_err === 1'b1) fe_count++;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "bench timed out");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_outputs(input string tag);
      check({tag, "_data"},  32'(rx_data),  32'(exp_data));
      check({tag, "_valid"}, 32'(rx_valid), 32'(exp_valid));
      check({tag, "_ovr"},   32'(overrun),  32'(exp_ovr));
   endtask

   task automatic model_ack();
      if (exp_valid) begin
         exp_valid = 1'b0;
         exp_ovr   = 1'b0;
      end
   endtask

   task automatic ack_byte(input string tag);
      rx_ack = 1'b1;
      tick(1);
      rx_ack = 1'b0;
      model_ack();
      check_outputs(tag);
   endtask

   task automatic idle(input int n);
      rx = 1'b1;
      tick(n);
   endtask

   // ack_mode: 0 none, 1 ack the previous byte during the start bit,
   // 2 ack in the cycle whose closing edge commits this frame.
   task automatic send_frame(input string tag, input logic [7:0] b, input logic stop_ok,
                             input int nstop, input int ack_mode);
      rx = 1'b0;
      if (ack_mode == 1) begin
         rx_ack = 1'b1;
         tick(1);
         rx_ack = 1'b0;
         model_ack();
         tick(BitClks - 1);
      end else begin
         tick(BitClks);
      end
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         tick(BitClks);
      end
      rx = stop_ok;
      tick(BitClks - 1);
      check({tag, "_pre_data"},  32'(rx_data),  32'(exp_data));
      check({tag, "_pre_valid"}, 32'(rx_valid), 32'(exp_valid));
      if (ack_mode == 2) rx_ack = 1'b1;
      tick(1);
      rx_ack = 1'b0;
      if (stop_ok) begin
         exp_ovr   = (ack_mode == 2) ? 1'b0 : (exp_valid | exp_ovr);
         exp_valid = 1'b1;
         exp_data  = b;
      end else if (ack_mode == 2) begin
         model_ack();
      end
      check_outputs({tag, "_post"});
      check({tag, "_ferr"}, 32'(frame_err), 32'(!stop_ok));
      if (stop_ok && nstop > 1) tick(BitClks * (nstop - 1));
   endtask

   initial begin
      int         fe0;
      logic [7:0] b;
      int         nstop;
      int         mode;

      rx        = 1'b1;
      rx_ack    = 1'b0;
      nrst      = 1'b0;
      exp_data  = 8'h00;
      exp_valid = 1'b0;
      exp_ovr   = 1'b0;
      tick(3);
      check_outputs("reset");
      check("reset_ferr", 32'(frame_err), 32'd0);
      nrst = 1'b1;
      idle(10);

      // Single frame, then consume it.
      send_frame("a5", 8'hA5, 1'b1, 1, 0);
      ack_byte("a5_ack");
      idle(4);

      // Back-to-back frames, each acknowledged.
      send_frame("b2b_00", 8'h00, 1'b1, 1, 0);
      send_frame("b2b_ff", 8'hFF, 1'b1, 1, 1);
      ack_byte("b2b_ack");
      idle(6);

      // Overrun: second byte lands on an unconsumed first one.
      send_frame("ovr_12", 8'h12, 1'b1, 1, 0);
      send_frame("ovr_34", 8'h34, 1'b1, 1, 0);
      ack_byte("ovr_ack");
      idle(6);

      // Framing error with a long break, then recovery.
      fe0 = fe_count;
      send_frame("ferr_55", 8'h55, 1'b0, 1, 0);
      rx = 1'b0;
      tick(20 * BitClks);
      check("ferr_pulses", 32'(fe_count - fe0), 32'd1);
      check("ferr_valid", 32'(rx_valid), 32'd0);
      idle(12);
      send_frame("rec_3c", 8'h3C, 1'b1, 1, 0);
      ack_byte("rec_ack");
      idle(6);

      // Short low glitch on the idle line.
      fe0 = fe_count;
      rx = 1'b0;
      tick(2);
      idle(70);
      check("glitch_valid", 32'(rx_valid), 32'd0);
      check("glitch_ferr", 32'(fe_count - fe0), 32'd0);
      send_frame("glitch_c3", 8'hC3, 1'b1, 1, 0);

      // Reset in the middle of a frame while a byte is pending.
      rx = 1'b0;
      tick(32);
      #2;
      nrst = 1'b0;
      rx   = 1'b1;
      #1;
      exp_data  = 8'h00;
      exp_valid = 1'b0;
      exp_ovr   = 1'b0;
      check_outputs("midrst");
      check("midrst_ferr", 32'(frame_err), 32'd0);
      tick(2);
      #2;
      nrst = 1'b1;
      idle(80);
      check_outputs("postrst");
      send_frame("rst_81", 8'h81, 1'b1, 2, 0);
      ack_byte("rst_ack");
      idle(4);

      // Ack coinciding with the commit of a second byte.
      send_frame("coinc_5a", 8'h5A, 1'b1, 1, 0);
      send_frame("coinc_96", 8'h96, 1'b1, 1, 2);
      ack_byte("coinc_ack");
      idle(4);

      // Random traffic.
      for (int n = 0; n < 10; n++) begin
         b     = 8'($urandom);
         nstop = 1 + int'($urandom_range(1, 0));
         mode  = int'($urandom_range(2, 0));
         send_frame("rand", b, 1'b1, nstop, mode);
         idle(int'($urandom_range(8, 0)));
      end
      ack_byte("rand_ack");

      check("total_ferr", 32'(fe_count), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
